sort_unit_sched: RTL and testbench

- Shares one fixed-latency, non-stallable four-element sort pipeline among p_nreqs requesters.
- Each requester has a val/rdy request port and a val/rdy response port.
- The scheduler arbitrates round-robin and issues at most one request per cycle.
- It tracks requester IDs through the pipeline and routes each sorted result into that requester's response queue.
- Issue is credit-gated, so results never drop even though the sort pipeline cannot stall.

---
 rtl/sort_sched_pkg.sv | 25 ++
 rtl/sort_sched_rsp_queue.sv | 71 +++++++
 rtl/sort_unit_sched.sv | 171 +++++++++++++++++
 tb/tb_sort_unit_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sort_sched_pkg
// Purpose  : Shared constants and sizing helpers for the sort-unit scheduler.
//            The 4-element message struct is declared at each user site from
//            p_nbits, using NELEMS from here.
// Revision : 1.0 - initial release
// ============================================================================
package sort_sched_pkg;

  // Elements per sort message.
  localparam int unsigned NELEMS = 4;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Counter width able to hold the value depth itself.
  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sort_sched_rsp_queue.sv
`default_nettype none
// ============================================================================
// Module   : sort_sched_rsp_queue
// Purpose  : Normal (non-bypass) circular queue holding sorted results for a
//            single requester.
// Ports    : clk, rst_n        - clock, async active-low reset
//            enq_val_i/rdy_o   - enqueue handshake, enq_msg_i payload
//            deq_val_o/rdy_i   - dequeue handshake, deq_msg_o payload
//            count_o           - current occupancy
// Revision : 1.0 - initial release
// ============================================================================
module sort_sched_rsp_queue
  import sort_sched_pkg::*;
#(
  parameter int unsigned p_width = 32,
  parameter int unsigned p_depth = 4,
  localparam int unsigned CW     = credit_width(p_depth)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enq_val_i,
  output logic               enq_rdy_o,
  input  logic [p_width-1:0] enq_msg_i,
  output logic               deq_val_o,
  input  logic               deq_rdy_i,
  output logic [p_width-1:0] deq_msg_o,
  output logic [CW-1:0]      count_o
);

  localparam int unsigned   PW   = id_width(p_depth);
  localparam logic [CW-1:0] FULL = CW'(p_depth);
  localparam logic [PW-1:0] LAST = PW'(p_depth - 1);

  logic [p_width-1:0] mem_q [p_depth];
  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               enq, deq;

  always_comb begin
    deq_val_o = (cnt_q != '0);
    // A full queue still accepts when the head leaves in the same cycle.
    enq_rdy_o = (cnt_q != FULL) || deq_rdy_i;
    deq       = deq_val_o && deq_rdy_i;
    enq       = enq_val_i && enq_rdy_o;
    wr_d      = enq ? ((wr_q == LAST) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d      = deq ? ((rd_q == LAST) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d     = cnt_q + CW'(enq) - CW'(deq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_q] <= enq_msg_i;
  end

  assign deq_msg_o = mem_q[rd_q];
  assign count_o   = cnt_q;

endmodule
`default_nettype wire

// File: rtl/sort_unit_sched.sv
`default_nettype none
// ============================================================================
// Module   : sort_unit_sched
// Purpose  : Shares one fixed-latency, non-stallable 4-element sort pipeline
//            among p_nreqs requesters. Round-robin, credit-gated issue; a tag
//            pipeline routes each result back to its requester's queue.
// Ports    : clk, rst_n              - clock, async active-low reset
//            req_val_i/req_rdy_o     - per-requester request handshake
//            req_msg_i               - packed requests, requester i at
//                                      [i*4*p_nbits +: 4*p_nbits]
//            resp_val_o/resp_rdy_i   - per-requester response handshake
//            resp_msg_o              - packed sorted results, same layout
//            su_in_val_o, su_in_o    - issue to the sort pipeline
//            su_out_val_i, su_out_i  - results from the sort pipeline
// Revision : 1.0 - initial release
// ============================================================================
module sort_unit_sched
  import sort_sched_pkg::*;
#(
  parameter int unsigned p_nbits = 8,
  parameter int unsigned p_nreqs = 2,
  parameter int unsigned p_lat   = 3,
  parameter int unsigned p_depth = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [p_nreqs-1:0]                req_val_i,
  output logic [p_nreqs-1:0]                req_rdy_o,
  input  logic [p_nreqs*NELEMS*p_nbits-1:0] req_msg_i,
  output logic [p_nreqs-1:0]                resp_val_o,
  input  logic [p_nreqs-1:0]                resp_rdy_i,
  output logic [p_nreqs*NELEMS*p_nbits-1:0] resp_msg_o,
  output logic                              su_in_val_o,
  output logic [NELEMS*p_nbits-1:0]         su_in_o,
  input  logic                              su_out_val_i,
  input  logic [NELEMS*p_nbits-1:0]         su_out_i
);

  localparam int unsigned MW  = NELEMS * p_nbits;
  localparam int unsigned IDW = id_width(p_nreqs);
  localparam int unsigned CW  = credit_width(p_depth);

  typedef struct packed {
    logic [p_nbits-1:0] e3, e2, e1, e0;
  } msg_t;

  typedef struct packed {
    logic           val;
    logic [IDW-1:0] id;
  } tag_t;

  logic               live_q;   // low for the first cycle after reset release
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [p_nreqs-1:0] elig, grant;
  logic [IDW-1:0]     gidx;
  logic               gany;
  msg_t               issue_msg;
  tag_t               tag_q [p_lat];
  tag_t               tail;
  logic [CW-1:0]      credit_q [p_nreqs];
  logic [CW-1:0]      credit_d [p_nreqs];
  logic [p_nreqs-1:0] q_enq_val, q_enq_rdy, deq;
  logic [CW-1:0]      q_count [p_nreqs];

  // --------------------------------------------------------------------------
  // Eligibility and round-robin arbitration starting at ptr_q
  // --------------------------------------------------------------------------
  always_comb begin
    int unsigned        idx;
    logic [p_nreqs-1:0] rot;
    idx  = 0;
    rot  = '0;
    gidx = '0;
    gany = 1'b0;
    for (int unsigned i = 0; i < p_nreqs; i++)
      elig[i] = live_q && req_val_i[i] && (credit_q[i] != '0);
    for (int unsigned k = 0; k < p_nreqs; k++) begin
      idx = (int'(ptr_q) + k) % p_nreqs;
      rot = elig >> idx;
      if (!gany && rot[0]) begin
        gany = 1'b1;
        gidx = IDW'(idx);
      end
    end
    grant = gany ? (p_nreqs'(1) << gidx) : '0;
    ptr_d = !gany ? ptr_q : ((gidx == IDW'(p_nreqs - 1)) ? '0 : gidx + 1'b1);
  end

  assign req_rdy_o   = grant;
  assign issue_msg   = gany ? msg_t'(req_msg_i[gidx*MW +: MW]) : '0;
  assign su_in_val_o = gany;
  assign su_in_o     = issue_msg;

  // --------------------------------------------------------------------------
  // Credits: one per free slot in the requester's queue, spent at issue
  // --------------------------------------------------------------------------
  always_comb begin
    for (int unsigned i = 0; i < p_nreqs; i++)
      credit_d[i] = credit_q[i] - CW'(grant[i]) + CW'(deq[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= 1'b0;
      ptr_q  <= '0;
      for (int unsigned i = 0; i < p_nreqs; i++) credit_q[i] <= CW'(p_depth);
      for (int unsigned k = 0; k < p_lat; k++)   tag_q[k]    <= '0;
    end else begin
      live_q   <= 1'b1;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      tag_q[0] <= '{val: gany, id: gidx};
      for (int unsigned k = 1; k < p_lat; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // Tail entry is aligned with su_out_val_i; a result is only accepted when
  // the tail says one was issued, so stale pipeline output is ignored.
  assign tail = tag_q[p_lat-1];

  // --------------------------------------------------------------------------
  // Per-requester response queues
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < p_nreqs; i++) begin : g_queue
    assign q_enq_val[i] = su_out_val_i && tail.val && (tail.id == IDW'(i));
    assign deq[i]       = resp_val_o[i] && resp_rdy_i[i];

    sort_sched_rsp_queue #(
      .p_width (MW),
      .p_depth (p_depth)
    ) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .enq_val_i (q_enq_val[i]),
      .enq_rdy_o (q_enq_rdy[i]),
      .enq_msg_i (su_out_i),
      .deq_val_o (resp_val_o[i]),
      .deq_rdy_i (resp_rdy_i[i]),
      .deq_msg_o (resp_msg_o[i*MW +: MW]),
      .count_o   (q_count[i])
    );
  end

`ifndef SYNTHESIS
  int unsigned inflight [p_nreqs];

  always_comb begin
    for (int unsigned i = 0; i < p_nreqs; i++) begin
      inflight[i] = 0;
      for (int unsigned k = 0; k < p_lat; k++)
        if (tag_q[k].val && (tag_q[k].id == IDW'(i))) inflight[i]++;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown(req_val_i))  else $error("req_val_i is X");
      assert (!$isunknown(resp_rdy_i)) else $error("resp_rdy_i is X");
      assert (su_out_val_i == tail.val) else $error("su_out_val_i disagrees with tag tail");
      for (int unsigned i = 0; i < p_nreqs; i++) begin
        assert (!(q_enq_val[i] && !q_enq_rdy[i])) else $error("enqueue into full queue %0d", i);
        assert (credit_q[i] <= CW'(p_depth)) else $error("credit %0d above depth", i);
        assert (int'(credit_q[i]) + int'(inflight[i]) + int'(q_count[i]) == int'(p_depth))
          else $error("credit accounting broken on requester %0d", i);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sort_unit_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_unit_sched
// Purpose  : Directed self-checking bench for sort_unit_sched with a 4-port
//            instance and a 3-cycle sort pipeline model behind su_*.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sort_unit_sched;

  localparam int NR = 4, NB = 8, LAT = 3, DEP = 4, MW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_val, req_rdy, resp_val, resp_rdy;
  logic [NR*MW-1:0]  req_msg, resp_msg;
  logic              su_in_val, su_out_val;
  logic [MW-1:0]     su_in, su_out;

  int n_checks = 0;
  int n_errors = 0;

  sort_unit_sched #(.p_nbits(NB), .p_nreqs(NR), .p_lat(LAT), .p_depth(DEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_val_i(req_val), .req_rdy_o(req_rdy), .req_msg_i(req_msg),
    .resp_val_o(resp_val), .resp_rdy_i(resp_rdy), .resp_msg_o(resp_msg),
    .su_in_val_o(su_in_val), .su_in_o(su_in),
    .su_out_val_i(su_out_val), .su_out_i(su_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int e0, input int e1, input int e2, input int e3);
    return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  function automatic logic [31:0] sort4(input logic [31:0] m);
    logic [7:0] e [4];
    logic [7:0] t;
    for (int i = 0; i < 4; i++) e[i] = m[i*8 +: 8];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (e[j] > e[j+1]) begin t = e[j]; e[j] = e[j+1]; e[j+1] = t; end
    return {e[3], e[2], e[1], e[0]};
  endfunction

  // Fixed-latency sort pipeline, reset together with the scheduler.
  logic        sm_v [LAT];
  logic [31:0] sm_d [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) begin sm_v[k] <= 1'b0; sm_d[k] <= '0; end
    end else begin
      sm_v[0] <= su_in_val;
      sm_d[0] <= sort4(su_in);
      for (int k = 1; k < LAT; k++) begin sm_v[k] <= sm_v[k-1]; sm_d[k] <= sm_d[k-1]; end
    end
  end
  assign su_out_val = sm_v[LAT-1];
  assign su_out     = sm_d[LAT-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  // Leaves the bench in the drive phase of cycle 0 (first cycle after release).
  task automatic do_reset();
    rst_n = 1'b0; req_val = '0; resp_rdy = '0; req_msg = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int acc0, g1, cnt, k, r, issued, got;
  logic hs0;
  logic [NR-1:0] hs;
  logic [31:0] exp_mem [NR][64];
  int wr [NR];
  int rd [NR];

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- single request and reset outputs ----------------
    rst_n = 1'b0; req_val = 4'b0010; resp_rdy = '0; req_msg = '0;
    req_msg[63:32] = pk(5, 5, 5, 5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_resp_val", resp_val, 0);
    chk("rst_su_in_val", su_in_val, 0);
    @(posedge clk); #1 rst_n = 1'b1;                       // cycle 0
    @(negedge clk);
    chk("c0_req_rdy", req_rdy, 0);
    chk("c0_su_in_val", su_in_val, 0);
    nxt(); req_val = '0;                                   // cycle 1
    nxt(); req_val = 4'b0001; req_msg[31:0] = pk(4, 3, 2, 1); // cycle 2
    @(negedge clk);
    chk("t1_su_in_val", su_in_val, 1);
    chk("t1_req_rdy", req_rdy, 4'b0001);
    chk("t1_su_in", su_in, pk(4, 3, 2, 1));
    nxt(); req_val = '0;                                   // cycle 3
    for (int c = 3; c < 6; c++) begin
      @(negedge clk); chk("t1_early_resp", resp_val, 0);
      nxt();
    end
    @(negedge clk);                                        // cycle 6
    chk("t1_resp_val", resp_val, 4'b0001);
    chk("t1_resp_msg", resp_msg[31:0], pk(1, 2, 3, 4));
    nxt(); resp_rdy = 4'b0001;
    @(negedge clk); chk("t1_resp_held", resp_val, 4'b0001);
    nxt();
    @(negedge clk); chk("t1_resp_drained", resp_val, 0);

    // ---------------- round robin ----------------
    do_reset(); nxt();                                     // cycle 1
    req_val = 4'b0011; resp_rdy = 4'b0011;
    req_msg[31:0] = pk(8, 7, 6, 5); req_msg[63:32] = pk(0, 9, 3, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_grant", req_rdy, (i % 2 == 0) ? 4'b0001 : 4'b0010);
      chk("t2_su_in", su_in, (i % 2 == 0) ? pk(8, 7, 6, 5) : pk(0, 9, 3, 3));
      nxt();
    end
    req_val = '0;                                          // cycle 5
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_resp_val", resp_val, (i % 2 == 0) ? 4'b0001 : 4'b0010);
      chk("t2_resp_msg", (i % 2 == 0) ? resp_msg[31:0] : resp_msg[63:32],
          (i % 2 == 0) ? pk(5, 6, 7, 8) : pk(0, 3, 3, 9));
      nxt();
    end

    // ---------------- credit stall ----------------
    do_reset();
    req_val = 4'b0011; resp_rdy = 4'b0010;
    req_msg[31:0] = pk(40, 30, 20, 10); req_msg[63:32] = pk(1, 1, 1, 1);
    acc0 = 0; g1 = 0; k = 0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      hs0 = req_rdy[0];
      if (req_rdy[0]) acc0++;
      if (c >= 8 && req_rdy[1]) g1++;
      if (c >= 8) chk("t3_rdy0_blocked", req_rdy[0], 0);
      nxt();
      if (hs0) begin k++; req_msg[31:0] = pk(40 + k, 30, 20, 10); end
    end
    chk("t3_accepted", acc0, 4);
    chk("t3_p1_served", g1 >= 2, 1);
    resp_rdy = 4'b0011;                                    // cycle 13
    @(negedge clk);
    chk("t3_head", resp_msg[31:0], pk(10, 20, 30, 40));
    chk("t3_rdy0_still0", req_rdy[0], 0);
    nxt(); resp_rdy = 4'b0010;
    cnt = 0;
    for (int c = 14; c <= 22; c++) begin
      @(negedge clk);
      hs0 = req_rdy[0];
      if (req_rdy[0]) cnt++;
      nxt();
      if (hs0) begin k++; req_msg[31:0] = pk(40 + k, 30, 20, 10); end
    end
    chk("t3_one_reissue", cnt, 1);

    // ---------------- queue full then streaming, order ----------------
    do_reset();
    k = 1; r = 1;
    req_val = 4'b0001; req_msg[31:0] = pk(k + 30, k + 20, k + 10, k);
    for (int c = 0; c < 100 && r <= 10; c++) begin
      @(negedge clk);
      hs0 = req_val[0] && req_rdy[0];
      if (c == 8) begin
        chk("t4_credit0", req_rdy[0], 0);
        chk("t4_full_val", resp_val, 4'b0001);
      end
      if (resp_val[0] && resp_rdy[0]) begin
        chk("t4_order", resp_msg[31:0], pk(r, r + 10, r + 20, r + 30));
        r++;
      end
      nxt();
      if (hs0) begin
        k++;
        if (k > 10) req_val = '0;
        else req_msg[31:0] = pk(k + 30, k + 20, k + 10, k);
      end
      if (c == 8) resp_rdy = 4'b0001;
    end
    chk("t4_count", r, 11);

    // ---------------- reset mid-flight ----------------
    do_reset();
    req_val = 4'b0001; req_msg[31:0] = pk(9, 8, 7, 6);
    repeat (4) nxt();
    req_val = '0;                                          // cycle 4
    nxt();
    @(negedge clk); chk("t5_pre_resp", resp_val, 4'b0001);
    nxt();
    rst_n = 1'b0;
    #1;
    chk("t5_async_resp", resp_val, 0);
    chk("t5_async_rdy", req_rdy, 0);
    chk("t5_async_su", su_in_val, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    req_val = 4'b0001; req_msg[31:0] = pk(2, 2, 1, 1);
    acc0 = 0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (req_rdy[0]) acc0++;
      if (c < 5) chk("t5_no_stale", resp_val, 0);
      if (c == 5) begin
        chk("t5_resp_val", resp_val, 4'b0001);
        chk("t5_resp_msg", resp_msg[31:0], pk(1, 1, 2, 2));
      end
      nxt();
    end
    chk("t5_credits", acc0, 4);

    // ---------------- full throughput, 4 ports ----------------
    do_reset();
    resp_rdy = 4'b1111; req_val = 4'b1111;
    for (int p = 0; p < NR; p++) begin
      req_msg[p*MW +: MW] = $urandom; wr[p] = 0; rd[p] = 0;
    end
    issued = 0; got = 0;
    for (int c = 0; c < 300 && got < 40; c++) begin
      @(negedge clk);
      if (c >= 1 && issued < 40) chk("t6_full_rate", su_in_val, 1);
      hs = '0;
      for (int p = 0; p < NR; p++) begin
        if (req_val[p] && req_rdy[p]) begin
          exp_mem[p][wr[p]] = sort4(req_msg[p*MW +: MW]);
          wr[p]++; issued++; hs[p] = 1'b1;
        end
        if (resp_val[p]) begin
          if (rd[p] < wr[p]) begin
            chk("t6_resp", resp_msg[p*MW +: MW], exp_mem[p][rd[p]]);
            rd[p]++; got++;
          end else begin
            chk("t6_unexpected_resp", resp_val[p], 0);
          end
        end
      end
      nxt();
      for (int p = 0; p < NR; p++) if (hs[p]) req_msg[p*MW +: MW] = $urandom;
      if (issued >= 40) req_val = '0;
    end
    chk("t6_issued", issued, 40);
    chk("t6_received", got, 40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
